// File: rtl/image_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : image_sequencer_pkg
// Description : Shared types and constants for the timestamp-scheduled frame
//               sequencer: FSM state encoding, queued command record and
//               interrupt bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package image_sequencer_pkg;

  // Slot field in the queued record is fixed-width so the struct can live in
  // the package; the top zero-extends the (narrower) port value into it.
  localparam int CMD_SLOT_W = 16;

  // irq_status bit positions
  localparam int IRQ_DRAINED = 0;
  localparam int IRQ_LATE    = 1;
  localparam int IRQ_ILLEGAL = 2;
  localparam int IRQ_W       = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TIME = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_SWITCH    = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [63:0]           timestamp;
    logic [CMD_SLOT_W-1:0] slot;
    logic                  expose;
  } cmd_t;

endpackage : image_sequencer_pkg
`default_nettype wire

// File: rtl/sequencer_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sequencer_cmd_fifo
// Description : Synchronous first-word-fall-through FIFO of cmd_t records.
//               DEPTH must be a power of two (>= 2) so the pointers wrap
//               naturally.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               push, push_data   - write request (ignored when full)
//               pop, head         - read request (ignored when empty), head
//               level             - registered occupancy 0..DEPTH
//               full, empty       - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sequencer_cmd_fifo
  import image_sequencer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  cmd_t                   push_data,
  input  logic                   pop,
  output cmd_t                   head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  cmd_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule : sequencer_cmd_fifo
`default_nettype wire

// File: rtl/image_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : image_sequencer
// Description : Timestamp-scheduled multi-slot frame sequencer. Queued
//               {timestamp, slot, expose} commands are executed when the
//               global time counter reaches the timestamp: the selected frame
//               slot is streamed from DRAM as bounded read bursts, then
//               image_change pulses and, optionally, camera_exposure_start
//               follows after EXPOSURE_DELAY cycles.
// Ports       : s_axi_aclk, image_sender_reset  - clock, sync active-high rst
//               counter, auto_start              - time base, run enable
//               cmd_*                            - command push interface
//               dram_read_*, dram_buffer_full    - DRAM burst request port
//               image_change, camera_exposure_start - event pulses
//               irq_*, late_count                - interrupt / status
//               queue_level, busy                - occupancy / activity
// Revision    : 1.0 - initial release
// ============================================================================
module image_sequencer
  import image_sequencer_pkg::*;
#(
  parameter int                         DRAM_ADDR_WIDTH = 39,
  parameter int                         DRAM_DATA_WIDTH = 128,
  parameter int                         NUM_SLOTS       = 8,
  parameter logic [DRAM_ADDR_WIDTH-1:0] SLOT_BASE       = '0,
  parameter logic [DRAM_ADDR_WIDTH-1:0] SLOT_STRIDE     = 'h10_0000,
  parameter int                         FRAME_BEATS     = 49152,
  parameter int                         BURST_LEN       = 64,
  parameter int                         CMD_DEPTH       = 16,
  parameter int                         EXPOSURE_DELAY  = 4,
  localparam int                        SLOT_W          = $clog2(NUM_SLOTS),
  localparam int                        LEVEL_W         = $clog2(CMD_DEPTH) + 1
) (
  input  logic                       s_axi_aclk,
  input  logic                       image_sender_reset,
  input  logic [63:0]                counter,
  input  logic                       auto_start,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [63:0]                cmd_timestamp,
  input  logic [SLOT_W:0]            cmd_slot,
  input  logic                       cmd_expose,
  output logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  output logic [7:0]                 dram_read_len,
  output logic                       dram_read_en,
  input  logic                       dram_read_busy,
  input  logic                       dram_buffer_full,
  output logic                       image_change,
  output logic                       camera_exposure_start,
  output logic                       irq_signal,
  output logic [IRQ_W-1:0]           irq_status,
  input  logic [IRQ_W-1:0]           irq_clear,
  output logic [15:0]                late_count,
  output logic [LEVEL_W-1:0]         queue_level,
  output logic                       busy
);

  localparam int AW    = DRAM_ADDR_WIDTH;
  localparam int BPB   = DRAM_DATA_WIDTH / 8;
  localparam int REM_W = $clog2(FRAME_BEATS + 1);
  localparam int EXP_W = $clog2(EXPOSURE_DELAY + 1);

  seq_state_t        state;
  seq_state_t        state_n;

  cmd_t              push_cmd;
  cmd_t              head_cmd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  logic [AW-1:0]     cur_addr;
  logic [REM_W-1:0]  remaining;
  logic [63:0]       ts;
  logic              expose;
  logic              first_wait;   // high only on the first WAIT_TIME cycle
  logic              ack_settled;  // high from the second WAIT_ACK cycle on
  logic [EXP_W-1:0]  exp_cnt;

  logic [8:0]        beats;
  logic              slot_illegal;
  logic              issue;
  logic              late_now;
  logic              load_exposure;
  logic [IRQ_W-1:0]  irq_set;

  // --------------------------------------------------------------------------
  // Command queue
  // --------------------------------------------------------------------------
  assign push_cmd = '{timestamp: cmd_timestamp,
                      slot:      CMD_SLOT_W'(cmd_slot),
                      expose:    cmd_expose};

  sequencer_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (s_axi_aclk),
    .rst       (image_sender_reset),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head_cmd),
    .level     (queue_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready    = !fifo_full;
  assign slot_illegal = (head_cmd.slot >= CMD_SLOT_W'(NUM_SLOTS));

  // Beats in the next burst: whatever is left, capped at BURST_LEN.
  assign beats = (32'(remaining) < 32'(BURST_LEN)) ? 9'(remaining) : 9'(BURST_LEN);

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk) begin
    if (image_sender_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    pop           = 1'b0;
    issue         = 1'b0;
    image_change  = 1'b0;
    load_exposure = 1'b0;
    late_now      = 1'b0;
    irq_set       = '0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && auto_start) begin
          pop = 1'b1;
          if (slot_illegal) begin
            irq_set[IRQ_ILLEGAL] = 1'b1;
          end else begin
            state_n = ST_WAIT_TIME;
          end
        end
      end
      ST_WAIT_TIME: begin
        if (first_wait && (counter > ts)) begin
          irq_set[IRQ_LATE] = 1'b1;
          late_now          = 1'b1;
        end
        if (counter >= ts) begin
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!dram_read_busy && !dram_buffer_full) begin
          issue   = 1'b1;
          state_n = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // The reader only raises busy the cycle after the strobe, so the
        // first WAIT_ACK cycle never looks at it.
        if (ack_settled && !dram_read_busy) begin
          state_n = (remaining != '0) ? ST_REQ : ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        image_change  = 1'b1;
        load_exposure = expose;
        if (fifo_empty) begin
          irq_set[IRQ_DRAINED] = 1'b1;
        end
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign dram_read_en = issue;
  assign busy         = (state != ST_IDLE);

  // --------------------------------------------------------------------------
  // Working registers, burst request registers, status
  // --------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk) begin
    if (image_sender_reset) begin
      cur_addr       <= '0;
      remaining      <= '0;
      ts             <= '0;
      expose         <= 1'b0;
      first_wait     <= 1'b0;
      ack_settled    <= 1'b0;
      dram_read_addr <= '0;
      dram_read_len  <= '0;
      irq_status     <= '0;
      late_count     <= '0;
    end else begin
      first_wait  <= (state != ST_WAIT_TIME) && (state_n == ST_WAIT_TIME);
      ack_settled <= (state == ST_WAIT_ACK);

      if (pop && !slot_illegal) begin
        ts        <= head_cmd.timestamp;
        expose    <= head_cmd.expose;
        cur_addr  <= SLOT_BASE + AW'(head_cmd.slot) * SLOT_STRIDE;
        remaining <= REM_W'(FRAME_BEATS);
      end

      // Request registers are loaded on entry to REQ so they are already
      // valid when the strobe fires, and hold until the next burst.
      if ((state != ST_REQ) && (state_n == ST_REQ)) begin
        dram_read_addr <= cur_addr;
        dram_read_len  <= 8'(beats - 9'd1);
      end

      if (issue) begin
        cur_addr  <= cur_addr + AW'(beats) * AW'(BPB);
        remaining <= remaining - REM_W'(beats);
      end

      // Set wins over a simultaneous clear.
      irq_status <= (irq_status & ~irq_clear) | irq_set;

      if (late_now && (late_count != 16'hFFFF)) begin
        late_count <= late_count + 16'd1;
      end
    end
  end

  assign irq_signal = |irq_status;

  // --------------------------------------------------------------------------
  // Exposure delay: loaded with EXPOSURE_DELAY on the cycle after the
  // image_change pulse, so the pulse on the count of 1 lands exactly
  // EXPOSURE_DELAY cycles after image_change. A reload restarts it.
  // --------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk) begin
    if (image_sender_reset) begin
      exp_cnt <= '0;
    end else if (load_exposure) begin
      exp_cnt <= EXP_W'(EXPOSURE_DELAY);
    end else if (exp_cnt != '0) begin
      exp_cnt <= exp_cnt - 1'b1;
    end
  end

  assign camera_exposure_start = (exp_cnt == EXP_W'(1));

endmodule : image_sequencer
`default_nettype wire

// File: tb/tb_image_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_sequencer
// Description : Directed self-checking bench for image_sequencer with a
//               150-beat frame, 64-beat bursts and a DRAM reader model that
//               holds busy for 10 cycles after each request strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_sequencer;

  localparam int AW = 39;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   counter = 64'd0;
  logic          auto_start;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [63:0]   cmd_timestamp;
  logic [3:0]    cmd_slot;
  logic          cmd_expose;
  logic [AW-1:0] dram_read_addr;
  logic [7:0]    dram_read_len;
  logic          dram_read_en;
  logic          dram_read_busy;
  logic          dram_buffer_full;
  logic          image_change;
  logic          camera_exposure_start;
  logic          irq_signal;
  logic [2:0]    irq_status;
  logic [2:0]    irq_clear;
  logic [15:0]   late_count;
  logic [4:0]    queue_level;
  logic          busy;

  int            n_cmp = 0;
  int            n_mis = 0;

  image_sequencer #(
    .FRAME_BEATS (150),
    .BURST_LEN   (64),
    .SLOT_STRIDE (39'h10_0000)
  ) dut (
    .s_axi_aclk            (clk),
    .image_sender_reset    (rst),
    .counter               (counter),
    .auto_start            (auto_start),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_timestamp         (cmd_timestamp),
    .cmd_slot              (cmd_slot),
    .cmd_expose            (cmd_expose),
    .dram_read_addr        (dram_read_addr),
    .dram_read_len         (dram_read_len),
    .dram_read_en          (dram_read_en),
    .dram_read_busy        (dram_read_busy),
    .dram_buffer_full      (dram_buffer_full),
    .image_change          (image_change),
    .camera_exposure_start (camera_exposure_start),
    .irq_signal            (irq_signal),
    .irq_status            (irq_status),
    .irq_clear             (irq_clear),
    .late_count            (late_count),
    .queue_level           (queue_level),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  // Free-running time base: value k holds for the whole k-th cycle.
  always @(posedge clk) counter <= counter + 64'd1;

  // DRAM reader model: busy for 10 cycles starting the cycle after en.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (rst)               busy_cnt <= 0;
    else if (dram_read_en) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign dram_read_busy = (busy_cnt != 0);

  // Event log sampled mid-cycle.
  logic [AW-1:0] en_addr_q [$];
  logic [7:0]    en_len_q  [$];
  logic [63:0]   en_ctr_q  [$];
  int            exp_n   = 0;
  logic [63:0]   exp_ctr = 64'd0;

  always @(negedge clk) begin
    if (dram_read_en) begin
      en_addr_q.push_back(dram_read_addr);
      en_len_q.push_back(dram_read_len);
      en_ctr_q.push_back(counter);
    end
    if (camera_exposure_start) begin
      exp_n   = exp_n + 1;
      exp_ctr = counter;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] t, input logic [3:0] s, input logic e);
    cmd_valid     = 1'b1;
    cmd_timestamp = t;
    cmd_slot      = s;
    cmd_expose    = e;
    step();
    cmd_valid     = 1'b0;
  endtask

  // Waits for the image_change pulse, returns the counter value of that
  // cycle and leaves the bench on the following negedge.
  task automatic wait_ic(input string tag, input int budget, output logic [63:0] at_ctr);
    int n;
    n = 0;
    while (image_change !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {63'd0, image_change === 1'b1}, 64'd1);
    at_ctr = counter;
    @(negedge clk);
  endtask

  logic [63:0] ic_ctr;
  logic [63:0] rel_ctr;

  initial begin
    rst              = 1'b1;
    auto_start       = 1'b0;
    cmd_valid        = 1'b0;
    cmd_timestamp    = 64'd0;
    cmd_slot         = 4'd0;
    cmd_expose       = 1'b0;
    dram_buffer_full = 1'b0;
    irq_clear        = 3'b000;

    // ---- Reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_queue_level", {59'd0, queue_level}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_irq_status", {61'd0, irq_status}, 64'd0);
    check("rst_outputs", {60'd0, dram_read_en, image_change, camera_exposure_start, irq_signal}, 64'd0);
    check("rst_addr_len", {17'd0, dram_read_addr, dram_read_len}, 64'd0);
    step();
    rst        = 1'b0;
    auto_start = 1'b1;

    // ---- Burst split: slot 2, ts=100 ----
    push(64'd100, 4'd2, 1'b0);
    wait_ic("t1_ic_seen", 300, ic_ctr);
    check("t1_en_count", 64'(en_addr_q.size()), 64'd3);
    check("t1_addr0", 64'(en_addr_q[0]), 64'h20_0000);
    check("t1_len0", 64'(en_len_q[0]), 64'd63);
    check("t1_ctr0", en_ctr_q[0], 64'd101);   // cycle after counter reached 100
    check("t1_addr1", 64'(en_addr_q[1]), 64'h20_0400);
    check("t1_len1", 64'(en_len_q[1]), 64'd63);
    check("t1_ctr1", en_ctr_q[1], 64'd113);
    check("t1_addr2", 64'(en_addr_q[2]), 64'h20_0800);
    check("t1_len2", 64'(en_len_q[2]), 64'd21);
    check("t1_ctr2", en_ctr_q[2], 64'd125);
    check("t1_ic_ctr", ic_ctr, 64'd137);
    check("t1_irq_drained", {61'd0, irq_status}, 64'd1);
    check("t1_late_count", {48'd0, late_count}, 64'd0);
    repeat (10) @(negedge clk);
    check("t1_no_exposure", 64'(exp_n), 64'd0);

    // ---- Late command ----
    step();
    irq_clear = 3'b111;
    step();
    irq_clear = 3'b000;
    @(negedge clk);
    check("t2_irq_cleared", {61'd0, irq_status}, 64'd0);
    step();
    push(64'd5, 4'd1, 1'b0);
    wait_ic("t2_ic_seen", 300, ic_ctr);
    check("t2_addr0", 64'(en_addr_q[3]), 64'h10_0000);
    check("t2_late_count", {48'd0, late_count}, 64'd1);
    check("t2_irq_status", {61'd0, irq_status}, 64'd3);
    step();
    irq_clear = 3'b011;
    step();
    irq_clear = 3'b000;
    @(negedge clk);
    check("t2_irq_signal_cleared", {63'd0, irq_signal}, 64'd0);

    // ---- Illegal slot, then a legal command ----
    step();
    push(counter + 64'd10, 4'd8, 1'b0);
    repeat (5) @(negedge clk);
    check("t3_no_en", 64'(en_addr_q.size()), 64'd6);
    check("t3_irq_illegal", {61'd0, irq_status}, 64'd4);
    check("t3_busy", {63'd0, busy}, 64'd0);
    step();
    push(counter + 64'd20, 4'd3, 1'b0);
    wait_ic("t3_ic_seen", 300, ic_ctr);
    check("t3_en_count", 64'(en_addr_q.size()), 64'd9);
    check("t3_addr0", 64'(en_addr_q[6]), 64'h30_0000);
    check("t3_late_count", {48'd0, late_count}, 64'd1);

    // ---- Backpressure ----
    step();
    dram_buffer_full = 1'b1;
    push(counter + 64'd5, 4'd0, 1'b0);
    repeat (29) step();
    check("t4_held_off", 64'(en_addr_q.size()), 64'd9);
    check("t4_busy_waiting", {63'd0, busy}, 64'd1);
    dram_buffer_full = 1'b0;
    rel_ctr = counter;
    wait_ic("t4_ic_seen", 300, ic_ctr);
    check("t4_en_at_release", en_ctr_q[9], rel_ctr);
    check("t4_addr0", 64'(en_addr_q[9]), 64'h0);

    // ---- Exposure ----
    step();
    push(counter + 64'd10, 4'd4, 1'b1);
    wait_ic("t5_ic_seen", 300, ic_ctr);
    repeat (10) @(negedge clk);
    check("t5_exp_count", 64'(exp_n), 64'd1);
    check("t5_exp_delay", exp_ctr - ic_ctr, 64'd4);
    check("t5_addr0", 64'(en_addr_q[12]), 64'h40_0000);

    // ---- FIFO full, then reset mid-frame ----
    step();
    auto_start = 1'b0;
    cmd_timestamp = counter + 64'd30;
    for (int i = 0; i < 17; i++) begin
      cmd_valid  = 1'b1;
      cmd_slot   = 4'(i % 8);
      cmd_expose = 1'b0;
      step();
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    check("t6_cmd_ready_full", {63'd0, cmd_ready}, 64'd0);
    check("t6_level_full", {59'd0, queue_level}, 64'd16);
    step();
    auto_start = 1'b1;
    begin
      int n;
      n = 0;
      while (dram_read_en !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("t6_mid_frame_en", {63'd0, dram_read_en}, 64'd1);
    check("t6_level_after_pop", {59'd0, queue_level}, 64'd15);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_level", {59'd0, queue_level}, 64'd0);
    check("t6_rst_busy", {63'd0, busy}, 64'd0);
    check("t6_rst_irq", {63'd0, irq_signal}, 64'd0);
    check("t6_rst_ready", {63'd0, cmd_ready}, 64'd1);
    check("t6_rst_late", {48'd0, late_count}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_image_sequencer
`default_nettype wire
